// File: rtl/mux_arb_2to1_if.sv
// Handshake bundle for mux_arb_2to1: two valid/ready input channels and one
// registered valid/ready output stream.
interface mux_arb_2to1_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_valid;
    logic             out_ready;

    // Source/sink side of the block (sources, downstream consumer).
    modport master (
        output a_data, a_valid, b_data, b_valid, out_ready,
        input  a_ready, b_ready, out_data, out_sel, out_valid
    );

    // The arbiter itself.
    modport slave (
        input  a_data, a_valid, b_data, b_valid, out_ready,
        output a_ready, b_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/mux_arb_2to1.sv
// Two-channel round-robin arbiter with burst limit feeding one registered output.
// Optional macro MUX_ARB_FIXED_PRIO_EN switches the grant to fixed A-over-B priority.
module mux_arb_2to1 #(
    parameter int WIDTH = 4,
    parameter int BURST = 2
) (
    input logic          clk,
    input logic          rst,
    mux_arb_2to1_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam logic [3:0] BURST_C = 4'(BURST);

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             last, last_nxt;      // last channel served: 0 = A, 1 = B
    logic             load;
    logic             grant_a, grant_b;
    logic             xfer_a, xfer_b;
    logic [WIDTH-1:0] data_q;
    logic             sel_q;
    logic             valid_q;

    assign load = !valid_q || bus.out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant_a = 1'b0;
        grant_b = 1'b0;
`ifdef MUX_ARB_FIXED_PRIO_EN
        grant_a = bus.a_valid;
        grant_b = !bus.a_valid && bus.b_valid;
`else
        unique case (state)
            OWN_A: begin
                if (bus.a_valid && (cnt < BURST_C || !bus.b_valid)) grant_a = 1'b1;
                else                                               grant_b = bus.b_valid;
            end
            OWN_B: begin
                if (bus.b_valid && (cnt < BURST_C || !bus.a_valid)) grant_b = 1'b1;
                else                                               grant_a = bus.a_valid;
            end
            default: begin
                if (bus.a_valid && bus.b_valid) begin
                    grant_a = last;
                    grant_b = !last;
                end else begin
                    grant_a = bus.a_valid;
                    grant_b = bus.b_valid;
                end
            end
        endcase
`endif
    end

    // Readies are forced low during reset so no word is taken and then discarded.
    assign bus.a_ready = !rst && load && grant_a;
    assign bus.b_ready = !rst && load && grant_b;
    assign xfer_a      = bus.a_valid && bus.a_ready;
    assign xfer_b      = bus.b_valid && bus.b_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        if (load) begin
            if (xfer_a) begin
                state_nxt = OWN_A;
                last_nxt  = 1'b0;
                cnt_nxt   = (state != OWN_A) ? 4'd1 : (cnt < BURST_C) ? cnt + 4'd1 : BURST_C;
            end else if (xfer_b) begin
                state_nxt = OWN_B;
                last_nxt  = 1'b1;
                cnt_nxt   = (state != OWN_B) ? 4'd1 : (cnt < BURST_C) ? cnt + 4'd1 : BURST_C;
            end else begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

    // Output stage: loads on a transfer, empties on an unfilled load, holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (load) begin
            if (xfer_a) begin
                data_q  <= bus.a_data;
                sel_q   <= 1'b0;
                valid_q <= 1'b1;
            end else if (xfer_b) begin
                data_q  <= bus.b_data;
                sel_q   <= 1'b1;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_mux_arb_2to1.sv
// Bench for mux_arb_2to1: table of per-cycle vectors with expected readies, plus a
// scoreboard queue of accepted words checked against the output register.
module tb_mux_arb_2to1;
    logic clk = 1'b0;
    logic rst;

    mux_arb_2to1_if #(.WIDTH(4)) bus ();

    mux_arb_2to1 #(.WIDTH(4), .BURST(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       a_v;
        logic [3:0] a_d;
        logic       b_v;
        logic [3:0] b_d;
        logic       o_r;
        logic       ar;
        logic       br;
    } vec_t;

    typedef struct packed {
        logic [3:0] data;
        logic       sel;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic a_v, input logic [3:0] a_d, input logic b_v,
                                input logic [3:0] b_d, input logic o_r, input logic ar,
                                input logic br);
        vec_t v;
        v.a_v = a_v; v.a_d = a_d; v.b_v = b_v; v.b_d = b_d;
        v.o_r = o_r; v.ar = ar; v.br = br;
        return v;
    endfunction

    // Called just after a rising edge: drive, compare at the falling edge, then advance.
    task automatic apply(input vec_t v, input int idx);
        sb_t e;
        bus.a_valid   = v.a_v;
        bus.a_data    = v.a_d;
        bus.b_valid   = v.b_v;
        bus.b_data    = v.b_d;
        bus.out_ready = v.o_r;
        @(negedge clk);
        check($sformatf("v%0d a_ready", idx), 8'(bus.a_ready), 8'(v.ar));
        check($sformatf("v%0d b_ready", idx), 8'(bus.b_ready), 8'(v.br));
        check($sformatf("v%0d out_valid", idx), 8'(bus.out_valid), 8'(sb.size() != 0));
        if (sb.size() != 0) begin
            check($sformatf("v%0d out_data", idx), 8'(bus.out_data), 8'(sb[0].data));
            check($sformatf("v%0d out_sel", idx), 8'(bus.out_sel), 8'(sb[0].sel));
            if (v.o_r) void'(sb.pop_front());
        end
        if (v.ar && v.a_v) begin e.data = v.a_d; e.sel = 1'b0; sb.push_back(e); end
        if (v.br && v.b_v) begin e.data = v.b_d; e.sel = 1'b1; sb.push_back(e); end
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef MUX_ARB_FIXED_PRIO_EN
        // Fixed priority: A always wins while valid; B only once A drops.
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 4'(i + 1), 1, 4'hF, 1, 1, 0));
        vecs.push_back(mk(0, 4'h0, 1, 4'hF, 1, 0, 1));
        vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0, 0));
`else
        // Contention with BURST=2: A,A,B,B,A,A.
        vecs.push_back(mk(1, 4'h0, 1, 4'hF, 1, 1, 0));
        vecs.push_back(mk(1, 4'h0, 1, 4'hF, 1, 1, 0));
        vecs.push_back(mk(1, 4'h0, 1, 4'hF, 1, 0, 1));
        vecs.push_back(mk(1, 4'h0, 1, 4'hF, 1, 0, 1));
        vecs.push_back(mk(1, 4'h0, 1, 4'hF, 1, 1, 0));
        vecs.push_back(mk(1, 4'h0, 1, 4'hF, 1, 1, 0));
        // Backpressure for 3 cycles, then B loads with no bubble.
        vecs.push_back(mk(1, 4'h0, 1, 4'hF, 0, 0, 0));
        vecs.push_back(mk(1, 4'h0, 1, 4'hF, 0, 0, 0));
        vecs.push_back(mk(1, 4'h0, 1, 4'hF, 0, 0, 0));
        vecs.push_back(mk(1, 4'h0, 1, 4'hF, 1, 0, 1));
        // Release: B drops, A takes over with cnt restarted (A wins again next cycle).
        vecs.push_back(mk(1, 4'h3, 0, 4'h0, 1, 1, 0));
        vecs.push_back(mk(1, 4'h4, 1, 4'h9, 1, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0, 0));
        // Single source A: 0x0 then 0x5.
        vecs.push_back(mk(1, 4'h0, 0, 4'h0, 1, 1, 0));
        vecs.push_back(mk(1, 4'h5, 0, 4'h0, 1, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0, 0));
        // From IDLE with last = A, simultaneous request goes to B.
        vecs.push_back(mk(1, 4'h7, 1, 4'h2, 1, 0, 1));
        vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0, 0));
        // Empty register loads even with out_ready low; full register then stalls.
        vecs.push_back(mk(0, 4'h0, 1, 4'h6, 0, 0, 1));
        vecs.push_back(mk(0, 4'h0, 1, 4'h8, 0, 0, 0));
        vecs.push_back(mk(0, 4'h0, 1, 4'h8, 1, 0, 1));
        vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0, 0));
`endif

        // Reset held for 2 edges with both valids high.
        rst           = 1'b1;
        bus.a_valid   = 1'b1;
        bus.a_data    = 4'h0;
        bus.b_valid   = 1'b1;
        bus.b_data    = 4'hF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("rst%0d a_ready", i), 8'(bus.a_ready), 8'd0);
            check($sformatf("rst%0d b_ready", i), 8'(bus.b_ready), 8'd0);
        end
        check("rst out_valid", 8'(bus.out_valid), 8'd0);
        check("rst out_data", 8'(bus.out_data), 8'd0);
        check("rst out_sel", 8'(bus.out_sel), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset mid-operation discards the word held in the output register.
        apply(mk(1, 4'hA, 0, 4'h0, 0, 1, 0), 100);
        rst         = 1'b1;
        bus.a_valid = 1'b0;
        @(negedge clk);
        check("midrst a_ready", 8'(bus.a_ready), 8'd0);
        check("midrst held out_valid", 8'(bus.out_valid), 8'd1);
        check("midrst held out_data", 8'(bus.out_data), 8'hA);
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        check("midrst out_valid", 8'(bus.out_valid), 8'd0);
        check("midrst out_data", 8'(bus.out_data), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(mk(1, 4'hC, 1, 4'hD, 1, 1, 0), 101);
        apply(mk(0, 4'h0, 0, 4'h0, 1, 0, 0), 102);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
